// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB4 register-bank completer with wait states, strobes, secure/RO protection and PSLVERR.
module apb_reg_completer #(
    parameter int                   ADDR        = 32,
    parameter int                   DATA        = 32,
    parameter int                   NUM_REGS    = 8,
    parameter int                   WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]  SECURE_MASK = '0,
    parameter logic [DATA-1:0]      RESET_VAL   = '0
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [2:0]               pprot,
    input  logic [ADDR-1:0]          paddr,
    input  logic [DATA-1:0]          pwdata,
    input  logic [DATA/8-1:0]        pstrb,
    output logic                     pready,
    output logic [DATA-1:0]          prdata,
    output logic                     pslverr,
    input  logic [NUM_REGS*DATA-1:0] hw_status,
    output logic [NUM_REGS*DATA-1:0] reg_out
);
    localparam int NB = DATA / 8;
    localparam int AW = $clog2(NB);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR-1:0] AMASK = ADDR'((1 << AW) - 1);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [IW-1:0] idx_q, idx_l, cur_idx;
    logic wr_q, err_q, err_l, cur_wr, cur_err, setup, in_range, commit;
    logic [ADDR-1:0] idx_full;
    logic [DATA-1:0] wdata_q, rd_val;
    logic [NB-1:0] strb_q;
    logic unused_prot;

    assign unused_prot = pprot[0] ^ pprot[2];
    assign setup    = psel & ~penable;
    assign idx_full = paddr >> AW;
    assign in_range = idx_full < ADDR'(NUM_REGS);
    assign idx_l    = idx_full[IW-1:0];
    assign err_l    = (|(paddr & AMASK)) | ~in_range |
                      (in_range & ((pwrite & RO_MASK[idx_l]) | (pprot[1] & SECURE_MASK[idx_l])));
    // With no wait states READY is entered on the setup edge itself, so use the live decode there
    assign cur_idx  = state == IDLE ? idx_l  : idx_q;
    assign cur_wr   = state == IDLE ? pwrite : wr_q;
    assign cur_err  = state == IDLE ? err_l  : err_q;
    assign rd_val   = (cur_wr | cur_err) ? '0 :
                      RO_MASK[cur_idx] ? hw_status[cur_idx*DATA +: DATA] : reg_out[cur_idx*DATA +: DATA];
    assign commit   = state == READY & psel & penable & wr_q & ~err_q;
    assign pready   = state == READY;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (setup) begin
                state_n = WAIT_STATES == 0 ? READY : WAIT;
                cnt_n   = 4'(WAIT_STATES);
            end
            WAIT: begin
                state_n = !psel ? IDLE : cnt == 4'd1 ? READY : WAIT;
                cnt_n   = psel ? cnt - 4'd1 : 4'd0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && setup) begin
                idx_q   <= idx_l;
                wr_q    <= pwrite;
                err_q   <= err_l;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
            if (state_n == READY) begin
                prdata  <= rd_val;
                pslverr <= cur_err;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_out[i*DATA +: DATA] = '0;
        end else begin : g_rw
            logic [DATA-1:0] r;
            always_ff @(posedge system_clock or posedge reset) begin
                if (reset)
                    r <= RESET_VAL;
                else if (commit && idx_q == IW'(i))
                    for (int k = 0; k < NB; k++)
                        if (strb_q[k]) r[8*k +: 8] <= wdata_q[8*k +: 8];
            end
            assign reg_out[i*DATA +: DATA] = r;
        end
    end
endmodule
